// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard unit and the
// downstream EX operand bypass mux.
package hazard_pkg;

   localparam int unsigned NREGS = 32;
   localparam int unsigned AW    = 5;

   // Operand source select registered into EX. Each code names the stage the
   // producer occupies once the consumer has reached EX.
   typedef enum logic [1:0] {
      BYP_RF  = 2'd0,
      BYP_MEM = 2'd1,
      BYP_WB  = 2'd2,
      BYP_WB2 = 2'd3
   } byp_sel_t;

   // A pipeline stage will write the register a decode operand reads.
   // x0 never matches.
   function automatic logic stage_hit(
      input logic          valid,
      input logic          wxd,
      input logic [AW-1:0] waddr,
      input logic [AW-1:0] rs,
      input logic          ren
   );
      return valid && wxd && ren && (waddr == rs) && (rs != '0);
   endfunction

   // Youngest producer wins: EX, then MEM, then WB, then the register file.
   function automatic byp_sel_t byp_pick(
      input logic ex_hit,
      input logic mem_hit,
      input logic wb_hit
   );
      if (ex_hit)       return BYP_MEM;
      else if (mem_hit) return BYP_WB;
      else if (wb_hit)  return BYP_WB2;
      else              return BYP_RF;
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-writeback scoreboard for long-latency writers (loads, mul/div).
// One bit per architectural register; x0 is never marked. A clear arriving
// this cycle is applied to the read ports immediately so dependent
// instructions release in the same cycle the writeback lands.
module hazard_scoreboard
   import hazard_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             set_en,
   input  logic [AW-1:0]    set_addr,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_addr,
   input  logic [AW-1:0]    rd_addr1,
   input  logic [AW-1:0]    rd_addr2,
   input  logic [AW-1:0]    rd_addr3,
   output logic             rd_pend1,
   output logic             rd_pend2,
   output logic             rd_pend3,
   output logic [NREGS-1:0] pending
);

   logic [NREGS-1:0] sb_q;
   logic [NREGS-1:0] sb_d;
   logic [NREGS-1:0] set_mask;
   logic [NREGS-1:0] clr_mask;
   logic [NREGS-1:0] sb_eff;

   // Build set/clear masks; the clear is folded in before the set so a
   // same-cycle set of the same register (younger writer) wins.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && (set_addr != '0)) begin
         set_mask[set_addr] = 1'b1;
      end
      if (clr_en) begin
         clr_mask[clr_addr] = 1'b1;
      end
      sb_eff   = sb_q & ~clr_mask;
      sb_d     = sb_eff | set_mask;
      rd_pend1 = sb_eff[rd_addr1];
      rd_pend2 = sb_eff[rd_addr2];
      rd_pend3 = sb_eff[rd_addr3];
   end

   // Scoreboard state; reset drops every outstanding writeback.
   always_ff @(posedge clk) begin
      if (reset) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

   assign pending = sb_q;

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage interlock and bypass-select generator for the 5-stage
// integer pipeline. Stalls decode on load-use, scoreboard RAW/WAW and
// in-flight long-latency producers, and registers per-operand bypass
// selects into EX.
// Build option: define HAZARD_BYPASS_EN to enable forwarding. Without it the
// selects are tied to BYP_RF and any RAW hit in EX/MEM/WB stalls decode.
module hazard_unit
   import hazard_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [AW-1:0]    id_rs1,
   input  logic             id_ren1,
   input  logic [AW-1:0]    id_rs2,
   input  logic             id_ren2,
   input  logic [AW-1:0]    id_waddr,
   input  logic             id_wxd,
   input  logic             ex_reg_valid,
   input  logic [AW-1:0]    ex_waddr,
   input  logic             ex_ctrl_wxd,
   input  logic             ex_ctrl_mem,
   input  logic             ex_ctrl_ll,
   input  logic             ex_kill,
   input  logic             mem_reg_valid,
   input  logic [AW-1:0]    mem_waddr,
   input  logic             mem_ctrl_wxd,
   input  logic             wb_reg_valid,
   input  logic [AW-1:0]    wb_waddr,
   input  logic             wb_ctrl_wxd,
   input  logic             ll_wb_valid,
   input  logic [AW-1:0]    ll_wb_waddr,
   output logic             id_stall,
   output logic [1:0]       ex_byp_sel1,
   output logic [1:0]       ex_byp_sel2,
   output logic [NREGS-1:0] sb_pending
);

   logic ex_hit1, ex_hit2;
   logic mem_hit1, mem_hit2;
   logic wb_hit1, wb_hit2;
   logic ex_hit;
   logic load_use;
   logic sb_raw;
   logic sb_waw;
   logic ll_hit;
   logic raw_nofwd;
   logic sb_set;
   logic pend1, pend2, pend3;

   assign sb_set = ex_reg_valid && ex_ctrl_wxd && ex_ctrl_ll && !ex_kill;

   hazard_scoreboard u_sb (
      .clk      (clk),
      .reset    (reset),
      .set_en   (sb_set),
      .set_addr (ex_waddr),
      .clr_en   (ll_wb_valid),
      .clr_addr (ll_wb_waddr),
      .rd_addr1 (id_rs1),
      .rd_addr2 (id_rs2),
      .rd_addr3 (id_waddr),
      .rd_pend1 (pend1),
      .rd_pend2 (pend2),
      .rd_pend3 (pend3),
      .pending  (sb_pending)
   );

   // Classify decode hazards against each in-flight writer and the scoreboard.
   always_comb begin
      ex_hit1  = stage_hit(ex_reg_valid,  ex_ctrl_wxd,  ex_waddr,  id_rs1, id_ren1);
      ex_hit2  = stage_hit(ex_reg_valid,  ex_ctrl_wxd,  ex_waddr,  id_rs2, id_ren2);
      mem_hit1 = stage_hit(mem_reg_valid, mem_ctrl_wxd, mem_waddr, id_rs1, id_ren1);
      mem_hit2 = stage_hit(mem_reg_valid, mem_ctrl_wxd, mem_waddr, id_rs2, id_ren2);
      wb_hit1  = stage_hit(wb_reg_valid,  wb_ctrl_wxd,  wb_waddr,  id_rs1, id_ren1);
      wb_hit2  = stage_hit(wb_reg_valid,  wb_ctrl_wxd,  wb_waddr,  id_rs2, id_ren2);
      ex_hit   = ex_hit1 || ex_hit2;
      load_use = ex_hit && ex_ctrl_mem && !ex_kill;
      sb_raw   = (pend1 && id_ren1) || (pend2 && id_ren2);
      sb_waw   = id_wxd && pend3;
      ll_hit   = ex_hit && ex_ctrl_ll;
`ifdef HAZARD_BYPASS_EN
      raw_nofwd = 1'b0;
`else
      // No forwarding network: every in-flight RAW must wait for the RF,
      // including WB since the register file is not write-first.
      raw_nofwd = ex_hit || mem_hit1 || mem_hit2 || wb_hit1 || wb_hit2;
`endif
      id_stall = id_valid && (load_use || sb_raw || sb_waw || ll_hit || raw_nofwd);
   end

`ifdef HAZARD_BYPASS_EN
   byp_sel_t sel1_q, sel1_d;
   byp_sel_t sel2_q, sel2_d;

   // Select per operand, shifted one stage since producer and consumer advance
   // together; a stalled or empty decode slot sends a bubble with no bypass.
   always_comb begin
      sel1_d = BYP_RF;
      sel2_d = BYP_RF;
      if (id_valid && !id_stall) begin
         sel1_d = byp_pick(ex_hit1, mem_hit1, wb_hit1);
         sel2_d = byp_pick(ex_hit2, mem_hit2, wb_hit2);
      end
   end

   // EX-stage bypass select registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel1_q <= BYP_RF;
         sel2_q <= BYP_RF;
      end else begin
         sel1_q <= sel1_d;
         sel2_q <= sel2_d;
      end
   end

   assign ex_byp_sel1 = sel1_q;
   assign ex_byp_sel2 = sel2_q;
`else
   assign ex_byp_sel1 = BYP_RF;
   assign ex_byp_sel2 = BYP_RF;
`endif

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Decode-stage interlock and bypass-select generator for the 5-stage integer pipeline.
- Keeps a 32-entry scoreboard of registers with pending long-latency writebacks (loads, mul/div). Raises a decode stall on load-use, scoreboard RAW and scoreboard WAW hazards.
- Registers per-operand bypass select codes into EX for the operand bypass mux directly downstream.

Parameters:
NREGS, 32, architectural integer registers; x0 hardwired zero
AW, 5, register address width (clog2(NREGS))

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  valid instruction in decode
id_rs1  in  AW  source 1 address
id_ren1  in  1  source 1 read
id_rs2  in  AW  source 2 address
id_ren2  in  1  source 2 read
id_waddr  in  AW  destination address
id_wxd  in  1  instruction writes a register
ex_reg_valid  in  1  EX stage valid
ex_waddr  in  AW  EX destination
ex_ctrl_wxd  in  1  EX writes a register
ex_ctrl_mem  in  1  EX is a load (data available at WB only)
ex_ctrl_ll  in  1  EX is a long-latency writer (goes to scoreboard)
ex_kill  in  1  squash EX this cycle
mem_reg_valid  in  1  MEM valid
mem_waddr  in  AW  MEM destination
mem_ctrl_wxd  in  1  MEM writes
wb_reg_valid  in  1  WB valid
wb_waddr  in  AW  WB destination
wb_ctrl_wxd  in  1  WB writes
ll_wb_valid  in  1  long-latency result written this cycle
ll_wb_waddr  in  AW  its destination
id_stall  out  1  hold decode, inject bubble into EX
ex_byp_sel1  out  2  registered select, operand 1
ex_byp_sel2  out  2  registered select, operand 2
sb_pending  out  NREGS  scoreboard bits (debug)

Behaviour:
- Reset state: all outputs and scoreboard 0; ex_byp_sel* = BYP_RF.
- Address x0 never matches any hazard and is never set in the scoreboard.
- Stage hit: stage valid && wxd && waddr == rs && ren && rs != 0.
- id_stall (combinational) = id_valid && any of:
  - (a) load-use: ex hit && ex_ctrl_mem && !ex_kill.
  - (b) scoreboard RAW: sb[rs1] && ren1, or sb[rs2] && ren2.
  - (c) scoreboard WAW: id_wxd && sb[id_waddr].
  - (d) ex hit && ex_ctrl_ll.
- Bypass select is computed at decode with priority EX > MEM > WB > RF and remapped one stage ahead, since the producer advances with the consumer: ex hit -> BYP_MEM(1), mem hit -> BYP_WB(2), wb hit -> BYP_WB2(3), else BYP_RF(0).
- ex_byp_sel* update on every cycle id_valid && !id_stall. They load BYP_RF on a stall or !id_valid, so the bubble carries no bypass.
- Scoreboard set: ex_reg_valid && ex_ctrl_wxd && ex_ctrl_ll && !ex_kill && ex_waddr != 0.
- Scoreboard clear: ll_wb_valid for ll_wb_waddr.
- Set and clear of the same register in the same cycle: set wins, because the new writer is younger.
- Clear of a non-pending bit: no effect.
- Clear of an address combinationally bypasses the scoreboard read that cycle, so a stall releases in the same cycle ll_wb_valid arrives.
- Reset mid-operation clears every pending bit; any outstanding ll writeback after reset is ignored.

Optional Feature:
- HAZARD_BYPASS_EN defined: behaviour as above.
- Undefined:
  - no forwarding; ex_byp_sel* tied to BYP_RF;
  - id_stall additionally asserts for any RAW hit in EX, MEM or WB (the WB hit covers the no-write-first register file);
  - the scoreboard is unchanged.

Decomposition:
- Package hazard_pkg holds:
  - typedef byp_sel_t (2-bit enum BYP_RF, BYP_MEM, BYP_WB, BYP_WB2), shared with the bypass mux;
  - constants NREGS and AW.
- One natural sub-module, hazard_scoreboard: set/clear/read ports and the clear-bypass logic. The top holds the compare/stall/select logic.

Test Plan:
- ALU RAW back-to-back: EX writes x5 (not mem/ll), ID reads rs1=x5 -> id_stall=0; next cycle ex_byp_sel1=1.
- Load-use: EX load to x7, ID rs2=x7 -> id_stall=1 for one cycle; then ex_byp_sel2=2.
- Long-latency: div to x9 passes EX, ID reads x9 -> stall held until ll_wb_valid with ll_wb_waddr=9, released the same cycle; sb_pending[9] cleared the following cycle.
- Same-cycle set/clear: EX ll to x3 while ll_wb_waddr=3 -> sb_pending[3]=1 next cycle.
- x0 and kill: ID reads x0 while EX loads x0 -> no stall; ll op to x4 with ex_kill=1 -> sb_pending[4] stays 0.
- Reset mid-stall: sb_pending[9]=1, stalled, reset=1 -> next cycle id_stall=0, sb_pending=0, sels=0; repeated with HAZARD_BYPASS_EN undefined: EX ALU hit on x5 -> stall.
